ufm_i2c_memory: RTL and testbench

- I2C slave giving an external master byte-wide read/write access to a 256 x 8 user non-volatile memory model.
- The storage is a synchronous register array standing in for the MAX II UFM block.
- Sits at the board-level I2C bus. Device address is partly strapped by pins a2/a1.
- Supports byte write (address + data) and current-address read.

---
 rtl/ufm_i2c_memory.sv | 121 ++++++++++++
 tb/tb_ufm_i2c_memory.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ufm_i2c_memory.sv
// ufm_i2c_memory: I2C slave with byte write and current-address read into a 256x8 register array
module ufm_i2c_memory #(
   parameter logic [4:0] DEV_ADDR_HI = 5'b10110,
   parameter logic [7:0] MEM_INIT    = 8'hFF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a1,
   input  logic a2,
   input  logic scl,
   inout  wire  sda
);
   typedef enum logic [2:0] {IDLE, DEV_ADDR, MEM_ADDR, WRITE, READ} state_t;
   state_t      state_q, state_d;
   logic [2:0]  scl_q, sda_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d, ptr_q, ptr_d;
   logic        oe_q, oe_d, wr_q, wr_d;
   logic [7:0]  mem_q [256];
   logic        scl_s, sda_s, rise, fall, start, stop, match, rx, rd;
   assign scl_s = scl_q[1];
   assign sda_s = sda_q[1];
   assign rise  = scl_s & ~scl_q[2];
   assign fall  = ~scl_s & scl_q[2];
   assign start = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
   assign stop  = scl_s & scl_q[2] & ~sda_q[2] & sda_s;
   assign match = sh_q[7:1] == {DEV_ADDR_HI, a2, a1};
   assign rx    = state_q inside {DEV_ADDR, MEM_ADDR, WRITE};
   assign rd    = state_q == READ;
   assign sda   = oe_q ? 1'b0 : 1'bz;
   // two synchronizer stages plus one history stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // next state: bus conditions first, then byte boundaries
   always_comb begin
      state_d = state_q;
      if (stop) state_d = IDLE;
      else if (start) state_d = DEV_ADDR;
      else if (fall && cnt_q == 4'd8 && state_q == DEV_ADDR && !match) state_d = IDLE;
      else if (fall && cnt_q == 4'd9 && state_q == DEV_ADDR) state_d = sh_q[0] ? READ : MEM_ADDR;
      else if (fall && cnt_q == 4'd9 && state_q == MEM_ADDR) state_d = WRITE;
      else if (rise && cnt_q == 4'd8 && rd && sda_s) state_d = IDLE;
   end
   // bit counting, shifting, pointer, ACK/data drive and write strobe
   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      ptr_d = ptr_q;
      oe_d  = oe_q;
      wr_d  = 1'b0;
      if (stop || start) begin
         cnt_d = 4'd0;
         oe_d  = 1'b0;
      end else if (rx && rise) begin
         if (cnt_q < 4'd8) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            wr_d  = state_q == WRITE && cnt_q == 4'd7;
         end else cnt_d = 4'd9;
      end else if (rx && fall) begin
         if (cnt_q == 4'd8) begin
            oe_d  = state_q != DEV_ADDR || match;
            ptr_d = state_q == MEM_ADDR ? sh_q : ptr_q;
         end else if (cnt_q == 4'd9) begin
            cnt_d = 4'd0;
            oe_d  = state_q == DEV_ADDR && sh_q[0] && !mem_q[ptr_q][7];
            sh_d  = state_q == DEV_ADDR && sh_q[0] ? mem_q[ptr_q] : sh_q;
         end
      end else if (rd && rise) begin
         if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
         else if (cnt_q == 4'd8) begin
            cnt_d = 4'd9;
            ptr_d = ptr_q + 8'd1;
         end
      end else if (rd && fall) begin
         if (cnt_q inside {[4'd1:4'd7]}) begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = !sh_q[6];
         end else if (cnt_q == 4'd8) oe_d = 1'b0;
         else if (cnt_q == 4'd9) begin
            sh_d  = mem_q[ptr_q];
            oe_d  = !mem_q[ptr_q][7];
            cnt_d = 4'd0;
         end
      end
   end
   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
         sh_q  <= 8'h00;
         ptr_q <= 8'h00;
         oe_q  <= 1'b0;
         wr_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
         ptr_q <= ptr_d;
         oe_q  <= oe_d;
         wr_q  <= wr_d;
      end
   end
   // storage array, written the clock after the last data bit is shifted in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem_q[i] <= MEM_INIT;
      end else if (wr_q) mem_q[ptr_q] <= sh_q;
   end
endmodule

// File: tb/tb_ufm_i2c_memory.sv
// tb_ufm_i2c_memory: scoreboard bench driving an I2C master against ufm_i2c_memory
module tb_ufm_i2c_memory;
   logic clk = 1'b0, rst_n, a1, a2, scl_m, sda_m;
   wire  sda;
   pullup (sda);
   assign sda = sda_m ? 1'bz : 1'b0;
   always #5 clk = ~clk;

   ufm_i2c_memory dut (.clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .scl(scl_m), .sda(sda));

   logic [8:0] q [$];
   int         nvec = 0, nmiss = 0, fno = 0, nb = 0, chk_n = 0, chk_seen = 0;
   logic [7:0] chk_got, chk_exp, sh;
   string      chk_nm;
   logic       scl_p = 1'b1, sda_p = 1'b1;
   logic [8:0] e;

   // bus monitor: collects 8 data bits plus the 9th (ACK) bit and scores each frame
   always @(scl_m or sda or rst_n or chk_n) begin
      if (chk_n != chk_seen) begin
         chk_seen = chk_n;
         nvec++;
         if (chk_got !== chk_exp) begin
            nmiss++;
            $display("FAIL %s: got %h, want %h", chk_nm, chk_got, chk_exp);
         end
      end
      if (!rst_n) nb = 0;
      else if (scl_m && !scl_p) begin
         if (nb < 8) begin
            sh = {sh[6:0], sda};
            nb++;
         end else begin
            nb = 0;
            fno++;
            nvec++;
            if (q.size() == 0) begin
               nmiss++;
               $display("FAIL frame%0d: unexpected frame byte %h ack %b", fno, sh, sda);
            end else begin
               e = q.pop_front();
               if ({sh, sda} !== e) begin
                  nmiss++;
                  $display("FAIL frame%0d: got byte %h ack %b, want byte %h ack %b", fno, sh, sda, e[8:1], e[0]);
               end
            end
         end
      end else if (scl_m && scl_p && sda !== sda_p) nb = 0;
      scl_p = scl_m;
      sda_p = sda;
   end

   task automatic chk(input logic [7:0] got, input logic [7:0] exp, input string nm);
      chk_got = got;
      chk_exp = exp;
      chk_nm  = nm;
      chk_n++;
      #1;
   endtask

   task automatic start_c();
      sda_m = 1'b1; scl_m = 1'b1; #80;
      sda_m = 1'b0; #80;
      scl_m = 1'b0; #80;
   endtask

   task automatic stop_c();
      sda_m = 1'b0; #80;
      scl_m = 1'b1; #80;
      sda_m = 1'b1; #80;
   endtask

   task automatic bit_c(input logic b);
      sda_m = b; #80;
      scl_m = 1'b1; #160;
      scl_m = 1'b0; #80;
   endtask

   task automatic wr_byte(input logic [7:0] d, input logic ack);
      q.push_back({d, ack});
      for (int i = 7; i >= 0; i--) bit_c(d[i]);
      bit_c(1'b1);
   endtask

   task automatic rd_byte(input logic [7:0] exp, input logic mack);
      q.push_back({exp, mack});
      for (int i = 0; i < 8; i++) bit_c(1'b1);
      bit_c(mack);
   endtask

   initial begin
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; a1 = 1'b0; a2 = 1'b0;
      #95 rst_n = 1'b1;
      #200 chk({7'd0, sda}, 8'h01, "reset_sda_released");
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'hAA, 1'b0); wr_byte(8'h5C, 1'b0); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'h5C, 1'b1); stop_c();
      start_c(); wr_byte(8'hB2, 1'b1); wr_byte(8'h12, 1'b1); wr_byte(8'h34, 1'b1); stop_c();
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'hAA, 1'b0); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'h5C, 1'b1); stop_c();
      a2 = 1'b1;
      start_c(); wr_byte(8'hB4, 1'b0); stop_c();
      start_c(); wr_byte(8'hB0, 1'b1); stop_c();
      a2 = 1'b0;
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'h01, 1'b0); wr_byte(8'h22, 1'b0); stop_c();
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'hFF, 1'b0); wr_byte(8'h11, 1'b0); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'h11, 1'b0); rd_byte(8'hFF, 1'b1); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'h22, 1'b1); stop_c();
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'h10, 1'b0);
      bit_c(1'b1); bit_c(1'b0); bit_c(1'b1); bit_c(1'b0); stop_c();
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'h10, 1'b0); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'hFF, 1'b1); stop_c();
      start_c(); wr_byte(8'hB0, 1'b0); wr_byte(8'hAA, 1'b0); stop_c();
      start_c(); wr_byte(8'hB1, 1'b0);
      sda_m = 1'b1; #20;
      chk({7'd0, sda}, 8'h00, "read_msb_driven");
      rst_n = 1'b0; #1;
      chk({7'd0, sda}, 8'h01, "reset_releases_sda");
      #24 rst_n = 1'b1; #100;
      stop_c();
      start_c(); wr_byte(8'hB1, 1'b0); rd_byte(8'hFF, 1'b1); stop_c();
      #200 chk(8'(q.size()), 8'h00, "scoreboard_drained");
      #1 $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end
endmodule
